alu_multicycle: RTL and testbench

Execution-stage ALU that consumes the 3-bit ALUControl code produced by the ALU control decoder and returns a registered ALUResult and Zero flag. Simple ops complete in one cycle. MUL uses an iterative radix-2 shift-add datapath that runs for WIDTH cycles. The start/busy/done handshake lets the control path stall the core while a multiply is in flight.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/mul_iter.sv | 71 +++++++
 rtl/alu_multicycle.sv | 157 +++++++++++++++
 tb/tb_alu_multicycle.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execution-stage ALU and the ALU control decoder.
//   - ALUControl operation codes (3 bits)
//   - 1-bit FSM state encoding for the multi-cycle ALU
// ---------------------------------------------------------------------------
package alu_pkg;

  // ALUControl operation codes. Codes 3'b011 and 3'b111 are not listed here
  // and execute as ADD.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  // Control FSM states: IDLE accepts work, MUL iterates the multiplier.
  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

endpackage : alu_pkg

// File: rtl/mul_iter.sv
// ---------------------------------------------------------------------------
// mul_iter
// Radix-2 shift-add multiplier datapath, one partial product per step.
// The caller sequences it: one load, then exactly WIDTH steps.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   load     in   capture a/b as multiplicand/multiplier, clear accumulator
//   step     in   process one multiplier bit
//   a        in   WIDTH  multiplicand operand
//   b        in   WIDTH  multiplier operand
//   product  out  WIDTH  accumulator value including the partial product of
//                        the current step (what the accumulator becomes at
//                        the next step edge); low WIDTH bits only
// ---------------------------------------------------------------------------
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_partial;
  logic [WIDTH-1:0] w_acc_next;

  // Partial product for the current multiplier LSB and the resulting sum.
  always_comb begin
    w_partial  = {WIDTH{1'b0}};
    if (r_mplier[0]) begin
      w_partial = r_mcand;
    end else begin
      w_partial = {WIDTH{1'b0}};
    end
    w_acc_next = r_acc + w_partial;
  end

  // Shift-add state: load operands, or advance one bit per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= {WIDTH{1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_acc    <= {WIDTH{1'b0}};
    end else if (load) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= {WIDTH{1'b0}};
    end else if (step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
    end else begin
      r_mcand  <= r_mcand;
      r_mplier <= r_mplier;
      r_acc    <= r_acc;
    end
  end

  // The top latches this on the final step edge, so it must already contain
  // the last partial product.
  assign product = w_acc_next;

endmodule : mul_iter

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
// Execution-stage ALU. Single-cycle ops (AND/OR/ADD/SUB/SLT) finish one edge
// after acceptance; MUL runs WIDTH iterations on the mul_iter datapath.
// The result register only changes on completion edges or reset.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset (wins over start)
//   start       in   request; accepted only while busy=0
//   ALUControl  in   3      operation code, sampled with start
//   SrcA        in   WIDTH  operand A, sampled with start
//   SrcB        in   WIDTH  operand B, sampled with start
//   ALUResult   out  WIDTH  registered result
//   Zero        out  1      ALUResult == 0
//   busy        out  1      high while a MUL is iterating
//   done        out  1      one-cycle pulse after ALUResult updates
// ---------------------------------------------------------------------------
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy,
  output logic             done
);

  // Counter spans 0..WIDTH-1; guard the degenerate WIDTH=1 case.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  alu_state_t       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_simple;
  logic [WIDTH-1:0] w_product;

  // Single-cycle operation result; unlisted codes (011, 111) fall to ADD.
  function automatic logic [WIDTH-1:0] simple_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] res;
    res = {WIDTH{1'b0}};
    case (op)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_SUB: res = a - b;
      ALU_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: res = a + b;
    endcase
    return res;
  endfunction

  // Request decode; start is only meaningful while idle.
  always_comb begin
    w_accept = 1'b0;
    w_is_mul = 1'b0;
    if ((r_state == IDLE) && start) begin
      w_accept = 1'b1;
    end else begin
      w_accept = 1'b0;
    end
    if (ALUControl == ALU_MUL) begin
      w_is_mul = 1'b1;
    end else begin
      w_is_mul = 1'b0;
    end
    w_load   = w_accept & w_is_mul;
    w_step   = (r_state == MUL);
    w_simple = simple_op(ALUControl, SrcA, SrcB);
  end

  mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul_iter (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .step    (w_step),
    .a       (SrcA),
    .b       (SrcB),
    .product (w_product)
  );

  // Control FSM, iteration counter, result register and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= {CW{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= {CW{1'b0}};
          if (w_accept && w_is_mul) begin
            r_state <= MUL;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else if (w_accept) begin
            r_result <= w_simple;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_done <= 1'b0;
            r_busy <= 1'b0;
          end
        end
        MUL: begin
          // No early exit: always WIDTH steps, start is ignored here.
          if (r_count == CNT_LAST) begin
            r_result <= w_product;
            r_state  <= IDLE;
            r_count  <= {CW{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_count <= r_count + CNT_ONE;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= {CW{1'b0}};
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ALUResult = r_result;
  assign Zero      = (r_result == {WIDTH{1'b0}});
  assign busy      = r_busy;
  assign done      = r_done;

endmodule : alu_multicycle

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32).
module tb_alu_multicycle;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        busy;
  logic        done;

  int checks;
  int errors;
  int n;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start      = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
  endtask

  // Issue a one-cycle op and check the cycle after the accept edge.
  task automatic one_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b);
    tick();
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_res"}, ALUResult, exp);
    check({tag, "_zero"}, {31'd0, Zero}, {31'd0, (exp == 32'd0)});
  endtask

  // Full MUL: accept, watch busy cycles with result frozen, check completion.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] prev, input logic [31:0] exp);
    int cnt;
    issue(3'b101, a, b);
    tick();
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      check({tag, "_hold"}, ALUResult, prev);
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
      cnt = cnt + 1;
      tick();
    end
    check({tag, "_busycycles"}, cnt, 32'd32);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_res"}, ALUResult, exp);
    check({tag, "_zero"}, {31'd0, Zero}, {31'd0, (exp == 32'd0)});
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    start      = 1'b0;
    ALUControl = 3'b000;
    SrcA       = 32'd0;
    SrcB       = 32'd0;

    // Reset
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_res", ALUResult, 32'h0000_0000);
    check("rst_zero", {31'd0, Zero}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    // Back-to-back single-cycle ops, each issued on the prior done cycle
    one_op("add_7_5", 3'b010, 32'd7, 32'd5, 32'h0000_000C);
    one_op("sub_5_5", 3'b100, 32'd5, 32'd5, 32'h0000_0000);
    one_op("sub_0_1", 3'b100, 32'd0, 32'd1, 32'hFFFF_FFFF);
    one_op("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
    one_op("slt_neg", 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h0000_0001);
    one_op("slt_swap", 3'b110, 32'd1, 32'hFFFF_FFFF, 32'h0000_0000);
    one_op("slt_eq", 3'b110, 32'd9, 32'd9, 32'h0000_0000);
    one_op("and", 3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    one_op("or", 3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    one_op("op111", 3'b111, 32'd2, 32'd3, 32'h0000_0005);
    one_op("op011", 3'b011, 32'd10, 32'd20, 32'h0000_001E);

    // Idle: done drops, result holds
    start = 1'b0;
    tick();
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_hold", ALUResult, 32'h0000_001E);

    // MUL
    run_mul("mul_a", 32'h0001_0003, 32'h0002_0005, 32'h0000_001E, 32'h000B_000F);
    run_mul("mul_neg", 32'hFFFF_FFFD, 32'd7, 32'h000B_000F, 32'hFFFF_FFEB);
    run_mul("mul_zero", 32'd0, 32'd0, 32'hFFFF_FFEB, 32'h0000_0000);
    start = 1'b0;
    tick();

    // start ignored while busy: MUL 6x7 with ADD 1+1 pulsed at busy cycle 5
    issue(3'b101, 32'd6, 32'd7);
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      check("ign_nodone", {31'd0, done}, 32'd0);
      check("ign_hold", ALUResult, 32'h0000_0000);
      n = n + 1;
      if (n == 5) issue(3'b010, 32'd1, 32'd1);
      tick();
      start = 1'b0;
    end
    check("ign_busycycles", n, 32'd32);
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_res", ALUResult, 32'h0000_002A);
    one_op("ign_next_add", 3'b010, 32'd1, 32'd1, 32'h0000_0002);
    start = 1'b0;
    tick();

    // Reset mid-MUL at busy cycle 10
    issue(3'b101, 32'd6, 32'd7);
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_res", ALUResult, 32'h0000_0000);
    check("mid_zero", {31'd0, Zero}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("mid_nodone", {31'd0, done | busy}, 32'd0);
    end
    one_op("mid_add_3_4", 3'b010, 32'd3, 32'd4, 32'h0000_0007);
    start = 1'b0;
    tick();
    check("end_done", {31'd0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_multicycle
